// File: rtl/controle_pkg.sv
// Purpose: shared encodings for the multicycle control unit (states, opcodes, mux selects).
// Latency: n/a (constants only).
// Backpressure: n/a.
package controle_pkg;

  // State encodings (6-bit); every other value is treated as illegal
  localparam logic [5:0] ST_FETCH     = 6'd0;
  localparam logic [5:0] ST_DECODE    = 6'd1;
  localparam logic [5:0] ST_EXEC      = 6'd2;
  localparam logic [5:0] ST_R_WB      = 6'd3;
  localparam logic [5:0] ST_I_WB      = 6'd4;
  localparam logic [5:0] ST_MEM_ADDR  = 6'd5;
  localparam logic [5:0] ST_MEM_READ  = 6'd6;
  localparam logic [5:0] ST_MEM_WB    = 6'd7;
  localparam logic [5:0] ST_MEM_WRITE = 6'd8;
  localparam logic [5:0] ST_XCHG_2    = 6'd9;
  localparam logic [5:0] ST_JAL_2     = 6'd10;
  localparam logic [5:0] ST_EXC_1     = 6'd11;
  localparam logic [5:0] ST_EXC_2     = 6'd12;
  localparam logic [5:0] ST_EXC_3     = 6'd13;

  // Opcodes
  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_JAL  = 6'h03;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;

  // Funct codes for opcode 0
  localparam logic [5:0] FN_XCHG  = 6'h05;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_BREAK = 6'h0D;
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_RTE   = 6'h13;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_SLT   = 6'h2A;

  // mem_add
  localparam logic [1:0] MA_PC     = 2'b00;
  localparam logic [1:0] MA_ALUOUT = 2'b01;
  localparam logic [1:0] MA_VETOR  = 2'b10;

  // pc_source
  localparam logic [2:0] PCS_JUMP   = 3'b000;
  localparam logic [2:0] PCS_ALU    = 3'b001;
  localparam logic [2:0] PCS_EPC    = 3'b010;
  localparam logic [2:0] PCS_ALUOUT = 3'b011;
  localparam logic [2:0] PCS_VETOR  = 3'b100;

  // alu_control
  localparam logic [2:0] ALU_PASS = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_SUB  = 3'b010;
  localparam logic [2:0] ALU_AND  = 3'b011;
  localparam logic [2:0] ALU_SLT  = 3'b111;

  // alu_src_b
  localparam logic [2:0] SRCB_B     = 3'b000;
  localparam logic [2:0] SRCB_IMM   = 3'b001;
  localparam logic [2:0] SRCB_4     = 3'b011;
  localparam logic [2:0] SRCB_IMMSH = 3'b100;

  // reg_dest
  localparam logic [2:0] RD_RT = 3'b000;
  localparam logic [2:0] RD_RD = 3'b001;
  localparam logic [2:0] RD_RA = 3'b010;
  localparam logic [2:0] RD_RS = 3'b011;

  // reg_data
  localparam logic [3:0] DAT_ALUOUT = 4'b0000;
  localparam logic [3:0] DAT_HILO   = 4'b0001;
  localparam logic [3:0] DAT_MDR    = 4'b0010;
  localparam logic [3:0] DAT_PC     = 4'b0011;
  localparam logic [3:0] DAT_B      = 4'b0100;
  localparam logic [3:0] DAT_XCHG   = 4'b0101;

  // exc_cause
  localparam logic [1:0] EXC_NONE   = 2'b00;
  localparam logic [1:0] EXC_OPCODE = 2'b01;
  localparam logic [1:0] EXC_OVF    = 2'b10;

endpackage

// File: rtl/contador_espera.sv
// Purpose: memory wait counter; load sets MEM_WAIT, then counts down to 0 and holds.
// Latency: fim is high in the cycle the count reaches 0 (MEM_WAIT cycles after load).
// Backpressure: none; load has priority over counting.
// Ports: clock, reset (async active-low), carga (load), fim (count is 0).
module contador_espera #(
  parameter int MEM_WAIT = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic carga,
  output logic fim
);

  localparam logic [2:0] VALOR = 3'(MEM_WAIT);

  logic [2:0] cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt <= 3'd0;
    end else if (carga) begin
      cnt <= VALOR;
    end else if (cnt != 3'd0) begin
      cnt <= cnt - 3'd1;
    end
  end

  assign fim = (cnt == 3'd0);

endmodule

// File: rtl/controle_multiciclo.sv
// Purpose: multicycle MIPS-style control FSM with invalid-opcode and overflow exceptions.
// Latency: FETCH MEM_WAIT+1 cycles, DECODE/EXEC 1 each, loads add MEM_WAIT read cycles.
// Backpressure: none; memory is modelled as a fixed MEM_WAIT-cycle latency.
// Ports: clock, reset (async active-low); opcode/funct from IR; alu_overflow/alu_zero flags;
//        write strobes, mux selects (mem_add, pc_source, alu_*, reg_dest, reg_data, mux_hilo),
//        estado (current state) and exc_cause (sticky cause of the last exception).
module controle_multiciclo
  import controle_pkg::*;
#(
  parameter int MEM_WAIT   = 2,
  parameter bit OVF_EXC_EN = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       alu_overflow,
  input  logic       alu_zero,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       ir_write,
  output logic       mem_write,
  output logic       reg_a_write,
  output logic       reg_b_write,
  output logic       reg_write,
  output logic       epc_write,
  output logic       xchg_reg_write,
  output logic [1:0] mem_add,
  output logic [2:0] pc_source,
  output logic [2:0] alu_control,
  output logic       alu_src_a,
  output logic [2:0] alu_src_b,
  output logic [2:0] reg_dest,
  output logic [3:0] reg_data,
  output logic       mux_hilo,
  output logic [5:0] estado,
  output logic [1:0] exc_cause
);

  logic [5:0] estado_r, estado_prox;
  logic [5:0] op_r, fn_r;
  logic [1:0] causa_r, causa_prox;
  logic       ativo;   // low from reset until the first edge after release
  logic       carga, fim;
  logic       r_ovf, i_ovf;

  // Only add/sub/addi trap on overflow; and/slt never do.
  assign r_ovf = OVF_EXC_EN && alu_overflow && ((fn_r == FN_ADD) || (fn_r == FN_SUB));
  assign i_ovf = OVF_EXC_EN && alu_overflow;

  // The counter is armed on entry to FETCH, MEM_ADDR and EXC_1. Arming one
  // state early for MEM_READ/EXC_2 makes those states last exactly MEM_WAIT
  // cycles, while FETCH (armed on entry) lasts MEM_WAIT+1.
  assign carga = !ativo ||
                 (((estado_prox == ST_FETCH) || (estado_prox == ST_MEM_ADDR) ||
                   (estado_prox == ST_EXC_1)) && (estado_prox != estado_r));

  contador_espera #(.MEM_WAIT(MEM_WAIT)) u_espera (
    .clock (clock),
    .reset (reset),
    .carga (carga),
    .fim   (fim)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_r <= ST_FETCH;
      ativo    <= 1'b0;
      causa_r  <= EXC_NONE;
      op_r     <= 6'd0;
      fn_r     <= 6'd0;
    end else begin
      ativo    <= 1'b1;
      estado_r <= estado_prox;
      causa_r  <= causa_prox;
      if (estado_r == ST_DECODE) begin
        op_r <= opcode;
        fn_r <= funct;
      end
    end
  end

  assign estado    = estado_r;
  assign exc_cause = causa_r;

  // Next state and exception cause
  always_comb begin
    estado_prox = estado_r;
    causa_prox  = causa_r;
    if (!ativo) begin
      estado_prox = ST_FETCH;
    end else begin
      case (estado_r)
        ST_FETCH:  if (fim) estado_prox = ST_DECODE;
        ST_DECODE: estado_prox = ST_EXEC;
        ST_EXEC: begin
          case (op_r)
            OP_R: begin
              case (fn_r)
                FN_ADD, FN_SUB, FN_AND, FN_SLT:             estado_prox = ST_R_WB;
                FN_JR, FN_MFHI, FN_MFLO, FN_BREAK, FN_RTE:  estado_prox = ST_FETCH;
                FN_XCHG:                                    estado_prox = ST_XCHG_2;
                default: begin
                  estado_prox = ST_EXC_1;
                  causa_prox  = EXC_OPCODE;
                end
              endcase
            end
            OP_J, OP_BEQ, OP_BNE: estado_prox = ST_FETCH;
            OP_JAL:               estado_prox = ST_JAL_2;
            OP_LW, OP_SW:         estado_prox = ST_MEM_ADDR;
            OP_ADDI:              estado_prox = ST_I_WB;
            default: begin
              estado_prox = ST_EXC_1;
              causa_prox  = EXC_OPCODE;
            end
          endcase
        end
        ST_R_WB: begin
          estado_prox = ST_FETCH;
          if (r_ovf) begin
            estado_prox = ST_EXC_1;
            causa_prox  = EXC_OVF;
          end
        end
        ST_I_WB: begin
          estado_prox = ST_FETCH;
          if (i_ovf) begin
            estado_prox = ST_EXC_1;
            causa_prox  = EXC_OVF;
          end
        end
        ST_MEM_ADDR:  estado_prox = (op_r == OP_LW) ? ST_MEM_READ : ST_MEM_WRITE;
        ST_MEM_READ:  if (fim) estado_prox = ST_MEM_WB;
        ST_EXC_1:     estado_prox = ST_EXC_2;
        ST_EXC_2:     if (fim) estado_prox = ST_EXC_3;
        ST_MEM_WB, ST_MEM_WRITE, ST_XCHG_2, ST_JAL_2, ST_EXC_3: estado_prox = ST_FETCH;
        default:      estado_prox = ST_FETCH;
      endcase
    end
  end

  // Outputs; everything is held at 0 until the first edge after reset.
  always_comb begin
    pc_write       = 1'b0;
    pc_write_cond  = 1'b0;
    ir_write       = 1'b0;
    mem_write      = 1'b0;
    reg_a_write    = 1'b0;
    reg_b_write    = 1'b0;
    reg_write      = 1'b0;
    epc_write      = 1'b0;
    xchg_reg_write = 1'b0;
    mem_add        = MA_PC;
    pc_source      = PCS_JUMP;
    alu_control    = ALU_PASS;
    alu_src_a      = 1'b0;
    alu_src_b      = SRCB_B;
    reg_dest       = RD_RT;
    reg_data       = DAT_ALUOUT;
    mux_hilo       = 1'b0;
    if (ativo) begin
      case (estado_r)
        ST_FETCH: begin
          if (fim) begin
            ir_write    = 1'b1;
            pc_write    = 1'b1;
            pc_source   = PCS_ALU;
            alu_control = ALU_ADD;
            alu_src_b   = SRCB_4;
          end
        end
        ST_DECODE: begin
          reg_a_write = 1'b1;
          reg_b_write = 1'b1;
          alu_control = ALU_ADD;
          alu_src_b   = SRCB_IMMSH;
        end
        ST_EXEC: begin
          case (op_r)
            OP_R: begin
              case (fn_r)
                FN_ADD: begin alu_src_a = 1'b1; alu_control = ALU_ADD; end
                FN_SUB: begin alu_src_a = 1'b1; alu_control = ALU_SUB; end
                FN_AND: begin alu_src_a = 1'b1; alu_control = ALU_AND; end
                FN_SLT: begin alu_src_a = 1'b1; alu_control = ALU_SLT; end
                FN_JR: begin
                  alu_src_a = 1'b1;
                  pc_write  = 1'b1;
                  pc_source = PCS_ALU;
                end
                FN_MFHI, FN_MFLO: begin
                  reg_write = 1'b1;
                  reg_dest  = RD_RD;
                  reg_data  = DAT_HILO;
                  mux_hilo  = (fn_r == FN_MFLO);
                end
                FN_BREAK: begin
                  // PC was already advanced in FETCH; step it back by 4
                  alu_control = ALU_SUB;
                  alu_src_b   = SRCB_4;
                  pc_write    = 1'b1;
                  pc_source   = PCS_ALU;
                end
                FN_RTE: begin
                  pc_write  = 1'b1;
                  pc_source = PCS_EPC;
                end
                FN_XCHG: begin
                  // Stash A, write old B into rs; XCHG_2 moves the stash into rt
                  xchg_reg_write = 1'b1;
                  reg_write      = 1'b1;
                  reg_dest       = RD_RS;
                  reg_data       = DAT_B;
                end
                default: ;
              endcase
            end
            OP_J: begin
              pc_write  = 1'b1;
              pc_source = PCS_JUMP;
            end
            OP_JAL: begin
              reg_write = 1'b1;
              reg_dest  = RD_RA;
              reg_data  = DAT_PC;
            end
            OP_BEQ, OP_BNE: begin
              // Compare runs here; alu_zero is the live flag of this compare,
              // so pc_write_cond leaves already qualified by branch sense.
              alu_src_a     = 1'b1;
              alu_control   = ALU_SUB;
              pc_source     = PCS_ALUOUT;
              pc_write_cond = (op_r == OP_BEQ) ? alu_zero : !alu_zero;
            end
            OP_ADDI: begin
              alu_src_a   = 1'b1;
              alu_control = ALU_ADD;
              alu_src_b   = SRCB_IMM;
            end
            default: ;
          endcase
        end
        ST_R_WB: begin
          reg_write = !r_ovf;
          reg_dest  = RD_RD;
          reg_data  = DAT_ALUOUT;
        end
        ST_I_WB: begin
          reg_write = !i_ovf;
          reg_dest  = RD_RT;
          reg_data  = DAT_ALUOUT;
        end
        ST_MEM_ADDR: begin
          alu_src_a   = 1'b1;
          alu_control = ALU_ADD;
          alu_src_b   = SRCB_IMM;
        end
        ST_MEM_READ: mem_add = MA_ALUOUT;
        ST_MEM_WB: begin
          reg_write = 1'b1;
          reg_dest  = RD_RT;
          reg_data  = DAT_MDR;
        end
        ST_MEM_WRITE: begin
          mem_add   = MA_ALUOUT;
          mem_write = 1'b1;
        end
        ST_XCHG_2: begin
          reg_write = 1'b1;
          reg_dest  = RD_RT;
          reg_data  = DAT_XCHG;
        end
        ST_JAL_2: begin
          pc_write  = 1'b1;
          pc_source = PCS_JUMP;
        end
        ST_EXC_1: begin
          epc_write   = 1'b1;
          alu_control = ALU_SUB;
          alu_src_b   = SRCB_4;
        end
        ST_EXC_2: mem_add = MA_VETOR;
        ST_EXC_3: begin
          pc_write  = 1'b1;
          pc_source = PCS_VETOR;
        end
        default: ;
      endcase
    end
  end

endmodule
